imm_gen_pipe: RTL

Parametrised, pipelined immediate generator for the decode stage of the out-of-order RISC-V core. It accepts an instruction word, a format select and a scheduler tag through a valid/ready handshake, and produces the XLEN-wide extended immediate one cycle later. A 2-entry skid buffer lets it absorb rename/dispatch back-pressure without a combinational ready path. It also supports flush on branch mispredict.

---
 rtl/imm_gen_pkg.sv | 27 ++
 rtl/imm_gen_pipe_extend.sv | 46 ++++
 rtl/imm_gen_pipe.sv | 82 ++++++++
 3 files changed

// File: rtl/imm_gen_pkg.sv
// imm_gen_pkg: shared constants for the decode-stage immediate generator.
//   - FMT_* : 3-bit immediate format select encodings
//   - ST_*  : FIFO occupancy states (state == entry count)
//   - entry_w()/ENTRY_W : width of one stored {imm, tag, err} entry
package imm_gen_pkg;

  localparam logic [2:0] FMT_I   = 3'd0;
  localparam logic [2:0] FMT_S   = 3'd1;
  localparam logic [2:0] FMT_B   = 3'd2;
  localparam logic [2:0] FMT_U   = 3'd3;
  localparam logic [2:0] FMT_J   = 3'd4;
  localparam logic [2:0] FMT_Z   = 3'd5;
  localparam logic [2:0] FMT_SH  = 3'd6;
  localparam logic [2:0] FMT_ILL = 3'd7;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  function automatic int entry_w(input int xlen, input int tag_w);
    return xlen + tag_w + 1;
  endfunction

  // Entry width for the default XLEN=32, TAG_W=6 build.
  localparam int ENTRY_W = entry_w(32, 6);

endpackage

// File: rtl/imm_gen_pipe_extend.sv
// imm_extend: combinational immediate decode/extension.
//   instr : raw 32-bit instruction word
//   fmt   : format select (FMT_*)
//   imm   : XLEN-wide extended immediate (0 for illegal fmt)
//   err   : high when fmt is the illegal encoding
module imm_extend
  import imm_gen_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  input  logic [2:0]      fmt,
  output logic [XLEN-1:0] imm,
  output logic            err
);

  // Every format is first formed as a 32-bit value with its sign already
  // folded in; zero-extended formats leave bit 31 clear, so a single
  // sign-extension to XLEN is correct for all of them.
  logic [31:0] imm32;

  always_comb begin
    imm32 = '0;
    err   = 1'b0;
    case (fmt)
      FMT_I:  imm32 = {{20{instr[31]}}, instr[31:20]};
      FMT_S:  imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      FMT_B:  imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                       instr[11:8], 1'b0};
      FMT_U:  imm32 = {instr[31:12], 12'b0};
      FMT_J:  imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                       instr[30:21], 1'b0};
      FMT_Z:  imm32 = {27'b0, instr[19:15]};
      FMT_SH: imm32 = (XLEN == 64) ? {26'b0, instr[25:20]}
                                   : {27'b0, instr[24:20]};
      default: err = 1'b1;
    endcase
  end

  assign imm = XLEN'($signed(imm32));

  // Opcode field is decoded elsewhere.
  logic unused_opc;
  assign unused_opc = ^instr[6:0];

endmodule

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: pipelined immediate generator with a 2-entry skid FIFO.
//   clk, rst           : clock, async active-high reset
//   flush              : synchronous flush, highest priority
//   in_valid/in_ready  : input handshake (in_ready depends on state only)
//   instr, fmt, in_tag : instruction, format select, scheduler tag
//   out_valid/out_ready: output handshake
//   out_imm, out_tag, out_err : head-of-FIFO entry
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [2:0]       fmt,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err
);

  localparam int EW = entry_w(XLEN, TAG_W);

  logic [XLEN-1:0] ext_imm;
  logic            ext_err;

  imm_extend #(.XLEN(XLEN)) u_ext (
    .instr (instr),
    .fmt   (fmt),
    .imm   (ext_imm),
    .err   (ext_err)
  );

  logic [1:0][EW-1:0] mem;
  logic [1:0]         cnt;
  logic               wptr, rptr;
  logic               push, pop;

  // Ready comes from registered occupancy only, so no out_ready -> in_ready
  // combinational path exists.
  assign in_ready  = (cnt != ST_TWO);
  assign out_valid = (cnt != ST_EMPTY);
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem  <= '0;
      cnt  <= ST_EMPTY;
      wptr <= 1'b0;
      rptr <= 1'b0;
    end else if (flush) begin
      // Entry data is left in place; only occupancy is discarded.
      cnt  <= ST_EMPTY;
      wptr <= 1'b0;
      rptr <= 1'b0;
    end else begin
      if (push) begin
        mem[wptr] <= {ext_imm, in_tag, ext_err};
        wptr      <= ~wptr;
      end
      if (pop) rptr <= ~rptr;
      case (cnt)
        ST_EMPTY: if (push)         cnt <= ST_ONE;
        ST_ONE:   if (push && !pop) cnt <= ST_TWO;
                  else if (!push && pop) cnt <= ST_EMPTY;
        ST_TWO:   if (pop)          cnt <= ST_ONE;
        default:                    cnt <= ST_EMPTY;
      endcase
    end
  end

  assign {out_imm, out_tag, out_err} = mem[rptr];

endmodule
